// File: rtl/force_cache_accum_if.sv
// Bus bundle for force_cache_accum: the incoming neighbour-force packet,
// the drain command and the outgoing drain stream.
interface force_cache_accum_if #(
    parameter int PARTICLE_ID_WIDTH = 8,
    parameter int FORCE_WIDTH       = 32
);
    logic [3*FORCE_WIDTH-1:0]     i_force;
    logic                         i_force_valid;
    logic [PARTICLE_ID_WIDTH-1:0] i_parid;
    logic                         i_drain_start;
    logic                         i_out_ready;
    logic [3*FORCE_WIDTH-1:0]     o_force;
    logic [PARTICLE_ID_WIDTH-1:0] o_parid;
    logic                         o_force_valid;
    logic                         o_accum_ready;
    logic                         o_drain_done;
    logic                         o_overflow;
    logic                         o_drop;

    modport master (
        output i_force, i_force_valid, i_parid, i_drain_start, i_out_ready,
        input  o_force, o_parid, o_force_valid, o_accum_ready, o_drain_done,
               o_overflow, o_drop
    );

    modport slave (
        input  i_force, i_force_valid, i_parid, i_drain_start, i_out_ready,
        output o_force, o_parid, o_force_valid, o_accum_ready, o_drain_done,
               o_overflow, o_drop
    );
endinterface

// File: rtl/force_cache_accum.sv
// Per-cell force accumulator: saturating read-modify-write into a per-particle
// RAM, then an in-order drain that clears every entry as it is accepted.
module force_cache_accum #(
    parameter int PARTICLE_ID_WIDTH = 8,
    parameter int FORCE_WIDTH       = 32
) (
    input  logic               clk,
    input  logic               rst,
    force_cache_accum_if.slave bus
);
    localparam int N  = 2**PARTICLE_ID_WIDTH;
    localparam int FW = FORCE_WIDTH;
    localparam int W  = 3*FORCE_WIDTH;

    typedef logic [PARTICLE_ID_WIDTH-1:0] id_t;
    typedef logic [W-1:0]                 vec_t;
    typedef enum logic [2:0] {S_CLEAR, S_ACCUM, S_FLUSH, S_DRAIN, S_DONE} state_t;

    // Returns {overflow, saturated sum}.
    function automatic logic [FW:0] sat_add(input logic [FW-1:0] a, input logic [FW-1:0] b);
        logic [FW:0] s;
        s = {a[FW-1], a} + {b[FW-1], b};
        if (s[FW] == s[FW-1]) return {1'b0, s[FW-1:0]};
        else if (s[FW])       return {2'b11, {(FW-1){1'b0}}};
        else                  return {2'b10, {(FW-1){1'b1}}};
    endfunction

    state_t state_q, state_d;
    id_t    clr_addr_q, clr_addr_d;
    logic   flush_cnt_q, flush_cnt_d;
    logic   s2_valid_q, s2_valid_d;
    id_t    s2_id_q, s2_id_d;
    vec_t   s2_force_q, s2_force_d;
    logic   fwd_valid_q, fwd_valid_d;
    vec_t   fwd_data_q, fwd_data_d;
    logic [PARTICLE_ID_WIDTH:0] rd_ptr_q, rd_ptr_d;
    logic   pend_q, pend_d;
    id_t    pend_id_q, pend_id_d;
    logic   out_valid_q, out_valid_d;
    id_t    out_id_q, out_id_d;
    vec_t   out_data_q, out_data_d;
    logic   pf_valid_q, pf_valid_d;
    id_t    pf_id_q, pf_id_d;
    vec_t   pf_data_q, pf_data_d;
    logic   overflow_q, overflow_d;
    logic   drop_q, drop_d;

    vec_t   mem [N];
    vec_t   ram_rdata;
    logic   ram_we, ram_re;
    id_t    ram_waddr, ram_raddr;
    vec_t   ram_wdata;

    vec_t       s2_opnd, sum;
    logic [2:0] ovf_c;
    logic [FW:0] sat_r [3];
    logic       accept, pop, issue, drain_act;
    logic [1:0] occ;

    // NOTE: RAM contents and read register are deliberately not reset; the
    // CLEAR sweep zeroes storage, and a reset would forbid block-RAM inference.
    always_ff @(posedge clk) begin
        if (ram_we) mem[ram_waddr] <= ram_wdata;
        if (ram_re) ram_rdata <= mem[ram_raddr];
    end

    assign s2_opnd = fwd_valid_q ? fwd_data_q : ram_rdata;

    for (genvar c = 0; c < 3; c++) begin : g_add
        assign sat_r[c]            = sat_add(s2_opnd[c*FW +: FW], s2_force_q[c*FW +: FW]);
        assign sum[c*FW +: FW]     = sat_r[c][FW-1:0];
        assign ovf_c[c]            = sat_r[c][FW];
    end

    // NOTE: every signal driven here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_d     = state_q;
        clr_addr_d  = clr_addr_q;
        flush_cnt_d = flush_cnt_q;
        rd_ptr_d    = rd_ptr_q;
        out_valid_d = out_valid_q;
        out_id_d    = out_id_q;
        out_data_d  = out_data_q;
        pf_valid_d  = pf_valid_q;
        pf_id_d     = pf_id_q;
        pf_data_d   = pf_data_q;
        pend_id_d   = pend_id_q;
        overflow_d  = overflow_q;
        drop_d      = drop_q;
        ram_we      = 1'b0;
        ram_waddr   = '0;
        ram_wdata   = '0;
        ram_re      = 1'b0;
        ram_raddr   = '0;

        accept    = bus.i_force_valid && (state_q == S_ACCUM);
        pop       = out_valid_q && bus.i_out_ready;
        drain_act = (state_q == S_DRAIN) || (state_q == S_FLUSH && flush_cnt_q);

        if (bus.i_force_valid && state_q != S_ACCUM) drop_d = 1'b1;

        // S1 issues the read; the forward flag covers a same-ID write this cycle.
        s2_valid_d  = accept;
        s2_id_d     = bus.i_parid;
        s2_force_d  = bus.i_force;
        fwd_valid_d = accept && s2_valid_q && (s2_id_q == bus.i_parid);
        fwd_data_d  = sum;
        if (accept) begin
            ram_re    = 1'b1;
            ram_raddr = bus.i_parid;
        end
        if (s2_valid_q) begin
            ram_we    = 1'b1;
            ram_waddr = s2_id_q;
            ram_wdata = sum;
            if (|ovf_c) overflow_d = 1'b1;
        end

        unique case (state_q)
            S_CLEAR: begin
                ram_we     = 1'b1;
                ram_waddr  = clr_addr_q;
                ram_wdata  = '0;
                clr_addr_d = clr_addr_q + 1'b1;
                if (&clr_addr_q) state_d = S_ACCUM;
            end
            S_ACCUM: begin
                if (bus.i_drain_start) begin
                    state_d     = S_FLUSH;
                    flush_cnt_d = 1'b0;
                    rd_ptr_d    = '0;
                end
            end
            S_FLUSH: begin
                flush_cnt_d = 1'b1;
                if (flush_cnt_q) state_d = S_DRAIN;
            end
            S_DRAIN: begin
                if (pop && (&out_id_q)) state_d = S_DONE;
            end
            S_DONE:  state_d = S_ACCUM;
            default: state_d = S_CLEAR;
        endcase

        if (pop) begin
            ram_we    = 1'b1;
            ram_waddr = out_id_q;
            ram_wdata = '0;
        end

        // Two-slot output buffer (out + prefetch) refilled from the RAM read.
        if (!out_valid_q || pop) begin
            if (pf_valid_q) begin
                out_valid_d = 1'b1;
                out_id_d    = pf_id_q;
                out_data_d  = pf_data_q;
                pf_valid_d  = pend_q;
                pf_id_d     = pend_id_q;
                pf_data_d   = ram_rdata;
            end else if (pend_q) begin
                out_valid_d = 1'b1;
                out_id_d    = pend_id_q;
                out_data_d  = ram_rdata;
            end else begin
                out_valid_d = 1'b0;
            end
        end else if (pend_q) begin
            pf_valid_d = 1'b1;
            pf_id_d    = pend_id_q;
            pf_data_d  = ram_rdata;
        end

        occ    = {1'b0, out_valid_q & ~pop} + {1'b0, pf_valid_q} + {1'b0, pend_q};
        issue  = drain_act && !rd_ptr_q[PARTICLE_ID_WIDTH] && (occ < 2'd2);
        pend_d = issue;
        if (issue) begin
            ram_re    = 1'b1;
            ram_raddr = rd_ptr_q[PARTICLE_ID_WIDTH-1:0];
            pend_id_d = rd_ptr_q[PARTICLE_ID_WIDTH-1:0];
            rd_ptr_d  = rd_ptr_q + 1'b1;
        end
    end

    // NOTE: state registers use non-blocking assignment so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_CLEAR;
            clr_addr_q  <= '0;
            flush_cnt_q <= 1'b0;
            s2_valid_q  <= 1'b0;
            s2_id_q     <= '0;
            s2_force_q  <= '0;
            fwd_valid_q <= 1'b0;
            fwd_data_q  <= '0;
            rd_ptr_q    <= '0;
            pend_q      <= 1'b0;
            pend_id_q   <= '0;
            out_valid_q <= 1'b0;
            out_id_q    <= '0;
            out_data_q  <= '0;
            pf_valid_q  <= 1'b0;
            pf_id_q     <= '0;
            pf_data_q   <= '0;
            overflow_q  <= 1'b0;
            drop_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            clr_addr_q  <= clr_addr_d;
            flush_cnt_q <= flush_cnt_d;
            s2_valid_q  <= s2_valid_d;
            s2_id_q     <= s2_id_d;
            s2_force_q  <= s2_force_d;
            fwd_valid_q <= fwd_valid_d;
            fwd_data_q  <= fwd_data_d;
            rd_ptr_q    <= rd_ptr_d;
            pend_q      <= pend_d;
            pend_id_q   <= pend_id_d;
            out_valid_q <= out_valid_d;
            out_id_q    <= out_id_d;
            out_data_q  <= out_data_d;
            pf_valid_q  <= pf_valid_d;
            pf_id_q     <= pf_id_d;
            pf_data_q   <= pf_data_d;
            overflow_q  <= overflow_d;
            drop_q      <= drop_d;
        end
    end

    assign bus.o_force       = out_data_q;
    assign bus.o_parid       = out_id_q;
    assign bus.o_force_valid = out_valid_q;
    assign bus.o_accum_ready = (state_q == S_ACCUM);
    assign bus.o_drain_done  = (state_q == S_DONE);
    assign bus.o_overflow    = overflow_q;
    assign bus.o_drop        = drop_q;
endmodule

// File: tb/tb_force_cache_accum.sv
// Directed bench for force_cache_accum: packet tables with hand-computed
// expected entries, plus drain, drop and mid-drain reset sequences.
module tb_force_cache_accum;
    localparam int PW = 8;
    localparam int FW = 32;
    localparam int N  = 256;

    typedef struct {
        logic [7:0]  id;
        logic [31:0] x;
        logic [31:0] y;
        logic [31:0] z;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    force_cache_accum_if #(.PARTICLE_ID_WIDTH(PW), .FORCE_WIDTH(FW)) bus ();
    force_cache_accum #(.PARTICLE_ID_WIDTH(PW), .FORCE_WIDTH(FW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int total = 0;
    int bad   = 0;

    logic [95:0] got [N];
    int got_cnt, order_err, stall_err, done_cnt, first_lat, first_hs, last_hs;

    task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [7:0] id, input logic [31:0] x,
                                input logic [31:0] y, input logic [31:0] z);
        vec_t v;
        v.id = id; v.x = x; v.y = y; v.z = z;
        return v;
    endfunction

    function automatic logic [95:0] f3(input vec_t v);
        return {v.z, v.y, v.x};
    endfunction

    // Applies packets on consecutive cycles; starts and ends at a negedge.
    task automatic send_table(input vec_t t[$]);
        foreach (t[i]) begin
            bus.i_force_valid = 1'b1;
            bus.i_parid       = t[i].id;
            bus.i_force       = f3(t[i]);
            @(negedge clk);
        end
        bus.i_force_valid = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic drain(input string tag, input bit rand_ready, input int inject_at);
        logic        held_v;
        logic [7:0]  held_id;
        logic [95:0] held_d;
        int          cyc;
        got_cnt = 0; order_err = 0; stall_err = 0; done_cnt = 0;
        first_lat = -1; first_hs = -1; last_hs = -1;
        held_v = 1'b0; held_id = '0; held_d = '0;
        foreach (got[i]) got[i] = 'x;
        bus.i_drain_start = 1'b1;
        @(negedge clk);
        bus.i_drain_start = 1'b0;
        for (cyc = 1; cyc < 3000; cyc++) begin
            if (cyc == inject_at) begin
                bus.i_force_valid = 1'b1;
                bus.i_parid       = 8'd7;
                bus.i_force       = {32'd0, 32'd0, 32'd555};
            end else begin
                bus.i_force_valid = 1'b0;
            end
            if (bus.o_drain_done) done_cnt++;
            if (held_v && (!bus.o_force_valid || bus.o_parid != held_id || bus.o_force != held_d))
                stall_err++;
            bus.i_out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            if (bus.o_force_valid && first_lat < 0) first_lat = cyc;
            if (bus.o_force_valid && bus.i_out_ready) begin
                if (bus.o_parid != 8'(got_cnt)) order_err++;
                got[bus.o_parid] = bus.o_force;
                got_cnt++;
                if (first_hs < 0) first_hs = cyc;
                last_hs = cyc;
            end
            held_v  = bus.o_force_valid && !bus.i_out_ready;
            held_id = bus.o_parid;
            held_d  = bus.o_force;
            if (got_cnt >= N && cyc >= last_hs + 4) break;
            @(negedge clk);
        end
        bus.i_force_valid = 1'b0;
        bus.i_out_ready   = 1'b1;
        check({tag, "_count"}, 96'(got_cnt), 96'(N));
        check({tag, "_order_errors"}, 96'(order_err), 96'd0);
        check({tag, "_stall_changes"}, 96'(stall_err), 96'd0);
        check({tag, "_done_pulses"}, 96'(done_cnt), 96'd1);
        check({tag, "_accum_ready_after"}, 96'(bus.o_accum_ready), 96'd1);
        check({tag, "_latency_le4"}, 96'(first_lat >= 1 && first_lat <= 4), 96'd1);
        if (!rand_ready) check({tag, "_span"}, 96'(last_hs - first_hs), 96'(N - 1));
    endtask

    task automatic check_entries(input string tag, input vec_t exps[$]);
        bit listed [N];
        int nz;
        foreach (listed[i]) listed[i] = 1'b0;
        foreach (exps[i]) begin
            listed[exps[i].id] = 1'b1;
            check($sformatf("%s_id%0d", tag, exps[i].id), got[exps[i].id], f3(exps[i]));
        end
        nz = 0;
        for (int i = 0; i < N; i++)
            if (!listed[i] && got[i] !== 96'd0) nz++;
        check({tag, "_others_zero"}, 96'(nz), 96'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t none[$];
        vec_t tab_a[$], exp_a[$];
        vec_t tab_s[$], exp_s[$];
        vec_t tab_r[$];
        bit   found, rdy;

        bus.i_force_valid = 1'b0;
        bus.i_parid       = '0;
        bus.i_force       = '0;
        bus.i_drain_start = 1'b0;
        bus.i_out_ready   = 1'b1;

        // Back-to-back same ID, then interleaved IDs.
        tab_a.push_back(mk(8'd5, 32'd1, 32'hFFFF_FFF9, 32'd0));
        tab_a.push_back(mk(8'd5, 32'd2, 32'd0, 32'd0));
        tab_a.push_back(mk(8'd5, 32'd3, 32'd0, 32'd0));
        tab_a.push_back(mk(8'd5, 32'd4, 32'd0, 32'd0));
        tab_a.push_back(mk(8'd3, 32'd100, 32'd0, 32'd0));
        tab_a.push_back(mk(8'd4, 32'd100, 32'd0, 32'd0));
        tab_a.push_back(mk(8'd3, 32'd100, 32'd0, 32'd0));
        tab_a.push_back(mk(8'd4, 32'd100, 32'd0, 32'd0));
        exp_a.push_back(mk(8'd5, 32'd10, 32'hFFFF_FFF9, 32'd0));
        exp_a.push_back(mk(8'd3, 32'd200, 32'd0, 32'd0));
        exp_a.push_back(mk(8'd4, 32'd200, 32'd0, 32'd0));

        // Saturation on ID 0, non-saturating negatives on the top ID.
        tab_s.push_back(mk(8'd0, 32'h7FFF_FFF0, 32'd0, 32'h8000_0000));
        tab_s.push_back(mk(8'd0, 32'h0000_0020, 32'd0, 32'hFFFF_FFFF));
        tab_s.push_back(mk(8'd255, 32'hFFFF_FFFF, 32'd5, 32'd0));
        tab_s.push_back(mk(8'd255, 32'hFFFF_FFFF, 32'd0, 32'd0));
        exp_s.push_back(mk(8'd0, 32'h7FFF_FFFF, 32'd0, 32'h8000_0000));
        exp_s.push_back(mk(8'd255, 32'hFFFF_FFFE, 32'd5, 32'd0));

        tab_r.push_back(mk(8'd150, 32'd9, 32'd0, 32'd0));
        tab_r.push_back(mk(8'd50, 32'hFFFF_FFFD, 32'd0, 32'd0));

        #2 rst = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_o_force", bus.o_force, 96'd0);
        check("rst_o_parid", 96'(bus.o_parid), 96'd0);
        check("rst_o_force_valid", 96'(bus.o_force_valid), 96'd0);
        check("rst_o_accum_ready", 96'(bus.o_accum_ready), 96'd0);
        check("rst_o_drain_done", 96'(bus.o_drain_done), 96'd0);
        check("rst_o_overflow", 96'(bus.o_overflow), 96'd0);
        check("rst_o_drop", 96'(bus.o_drop), 96'd0);

        rst = 1'b1;
        for (int k = 1; k <= N; k++) begin
            @(negedge clk);
            if (k == N - 1) check("ready_low_before_N", 96'(bus.o_accum_ready), 96'd0);
            if (k == N)     check("ready_high_at_N", 96'(bus.o_accum_ready), 96'd1);
        end

        drain("zero", 1'b0, 0);
        check_entries("zero", none);

        send_table(tab_a);
        drain("mix", 1'b1, 0);
        check_entries("mix", exp_a);
        check("overflow_still_clear", 96'(bus.o_overflow), 96'd0);

        send_table(tab_s);
        check("drop_clear_before", 96'(bus.o_drop), 96'd0);
        drain("sat", 1'b0, 0);
        check_entries("sat", exp_s);
        check("overflow_set", 96'(bus.o_overflow), 96'd1);

        drain("redrain", 1'b1, 6);
        check_entries("redrain", none);
        check("drop_set", 96'(bus.o_drop), 96'd1);
        check("overflow_sticky", 96'(bus.o_overflow), 96'd1);

        send_table(tab_r);
        bus.i_out_ready   = 1'b1;
        bus.i_drain_start = 1'b1;
        @(negedge clk);
        bus.i_drain_start = 1'b0;
        found = 1'b0;
        for (int k = 0; k < 600 && !found; k++) begin
            if (bus.o_force_valid && bus.o_parid == 8'd100) found = 1'b1;
            else @(negedge clk);
        end
        check("reach_p100", 96'(found), 96'd1);
        #2 rst = 1'b0;
        #1;
        check("midrst_valid", 96'(bus.o_force_valid), 96'd0);
        check("midrst_overflow", 96'(bus.o_overflow), 96'd0);
        check("midrst_drop", 96'(bus.o_drop), 96'd0);
        @(negedge clk);
        rst = 1'b1;
        rdy = 1'b0;
        for (int k = 0; k < N + 10 && !rdy; k++) begin
            @(negedge clk);
            rdy = bus.o_accum_ready;
        end
        check("ready_after_midrst", 96'(rdy), 96'd1);
        drain("post_rst", 1'b0, 0);
        check_entries("post_rst", none);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
